// File: rtl/svpwm_gate_decoder_if.sv
`default_nettype none
// svpwm_gate_decoder_if: six-switch SVPWM gate bus plus the decoded half-period results.
// Rev 1.0
interface svpwm_gate_decoder_if #(
  parameter int CNT_W = 8
);
  logic             T_1, T_2, T_3;
  logic             T_4, T_5, T_6;
  logic [3:0]       sektor;
  logic [CNT_W-1:0] time_vector1;
  logic [CNT_W-1:0] time_vector2;
  logic             dir;
  logic             valid;
  logic             gates_off;
  logic             shoot_fault;
  logic             dead_fault;
  logic             seq_err;

  modport master (
    output T_1, T_2, T_3, T_4, T_5, T_6,
    input  sektor, time_vector1, time_vector2, dir, valid,
    input  gates_off, shoot_fault, dead_fault, seq_err
  );

  modport slave (
    input  T_1, T_2, T_3, T_4, T_5, T_6,
    output sektor, time_vector1, time_vector2, dir, valid,
    output gates_off, shoot_fault, dead_fault, seq_err
  );
endinterface
`default_nettype wire

// File: rtl/svpwm_gate_decoder.sv
`default_nettype none
// svpwm_gate_decoder: passive gate-bus monitor recovering sector/dwell per half-period and flagging faults.
// Rev 1.0
module svpwm_gate_decoder #(
  parameter int DEAD_MAX = 4,
  parameter int CNT_W    = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  svpwm_gate_decoder_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    ACT1 = 2'd2,
    ACT2 = 2'd3
  } state_t;

  localparam int               DW       = $clog2(DEAD_MAX + 2);
  localparam logic [DW-1:0]    DEAD_LIM = DW'(DEAD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  logic [2:0]       up, lo, code_q, code, cidx, dead_hit;
  logic             gates_off_q, is_zero, fire, err, dir_nx;
  state_t           state, state_nx;
  logic [2:0]       idx_a, idx_b, idx_a_nx, idx_b_nx, sek_nx;
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_a_nx, cnt_b_nx, t1_nx, t2_nx;

  function automatic logic [2:0] vec_idx(input logic [2:0] c);
    case (c)
      3'b101:  return 3'd0;
      3'b001:  return 3'd1;
      3'b011:  return 3'd2;
      3'b010:  return 3'd3;
      3'b110:  return 3'd4;
      3'b100:  return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] nxt6(input logic [2:0] i);
    return (i == 3'd5) ? 3'd0 : i + 3'd1;
  endfunction

  function automatic logic [2:0] prv6(input logic [2:0] i);
    return (i == 3'd0) ? 3'd5 : i - 3'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_SAT) ? c : c + CNT_ONE;
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      up          <= '0;
      lo          <= '0;
      gates_off_q <= 1'b0;
      code_q      <= '0;
    end else begin
      up          <= {bus.T_3, bus.T_2, bus.T_1};
      lo          <= {bus.T_6, bus.T_5, bus.T_4};
      gates_off_q <= ~|{bus.T_1, bus.T_2, bus.T_3, bus.T_4, bus.T_5, bus.T_6};
      code_q      <= code;
    end
  end

  // A leg in its dead band keeps the last driven level so dead time counts toward the outgoing vector
  always_comb begin
    code = code_q;
    for (int i = 0; i < 3; i++) begin
      if (up[i] || lo[i] || gates_off_q) code[i] = up[i];
    end
  end

  assign cidx    = vec_idx(code);
  assign is_zero = (code == 3'b000) || (code == 3'b111);

  for (genvar g = 0; g < 3; g++) begin : g_leg
    logic [DW-1:0] dead_cnt;
    always_ff @(posedge CLK) begin
      if (!RST_N)                          dead_cnt <= '0;
      else if (up[g] || lo[g] || gates_off_q) dead_cnt <= '0;
      else if (dead_cnt != DEAD_LIM)       dead_cnt <= dead_cnt + DW'(1);
    end
    assign dead_hit[g] = (dead_cnt == DEAD_LIM);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    idx_a_nx = idx_a;
    idx_b_nx = idx_b;
    cnt_a_nx = cnt_a;
    cnt_b_nx = cnt_b;
    fire     = 1'b0;
    err      = 1'b0;
    sek_nx   = idx_a;
    t1_nx    = cnt_a;
    t2_nx    = '0;
    dir_nx   = 1'b0;
    if (gates_off_q) begin
      state_nx = IDLE;
      cnt_a_nx = '0;
      cnt_b_nx = '0;
    end else begin
      case (state)
        IDLE: if (is_zero) state_nx = ZERO;
        ZERO: begin
          if (!is_zero) begin
            state_nx = ACT1;
            idx_a_nx = cidx;
            cnt_a_nx = CNT_ONE;
            cnt_b_nx = '0;
          end
        end
        ACT1: begin
          if (is_zero) begin
            fire     = 1'b1;
            state_nx = ZERO;
          end else if (cidx == idx_a) begin
            cnt_a_nx = sat_inc(cnt_a);
          end else if (cidx == nxt6(idx_a) || cidx == prv6(idx_a)) begin
            state_nx = ACT2;
            idx_b_nx = cidx;
            cnt_b_nx = CNT_ONE;
          end else begin
            err      = 1'b1;
            state_nx = IDLE;
          end
        end
        ACT2: begin
          if (is_zero) begin
            fire     = 1'b1;
            state_nx = ZERO;
            if (idx_b == nxt6(idx_a)) begin
              t2_nx = cnt_b;
            end else begin
              sek_nx = idx_b;
              t1_nx  = cnt_b;
              t2_nx  = cnt_a;
              dir_nx = 1'b1;
            end
          end else if (cidx == idx_b) begin
            cnt_b_nx = sat_inc(cnt_b);
          end else begin
            err      = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      idx_a            <= '0;
      idx_b            <= '0;
      cnt_a            <= '0;
      cnt_b            <= '0;
      bus.sektor       <= '0;
      bus.time_vector1 <= '0;
      bus.time_vector2 <= '0;
      bus.dir          <= 1'b0;
      bus.valid        <= 1'b0;
      bus.seq_err      <= 1'b0;
      bus.shoot_fault  <= 1'b0;
      bus.dead_fault   <= 1'b0;
    end else begin
      idx_a       <= idx_a_nx;
      idx_b       <= idx_b_nx;
      cnt_a       <= cnt_a_nx;
      cnt_b       <= cnt_b_nx;
      bus.valid   <= fire;
      bus.seq_err <= err;
      if (fire) begin
        bus.sektor       <= {1'b0, sek_nx};
        bus.time_vector1 <= t1_nx;
        bus.time_vector2 <= t2_nx;
        bus.dir          <= dir_nx;
      end
      bus.shoot_fault <= bus.shoot_fault | (|(up & lo));
      bus.dead_fault  <= bus.dead_fault | (|dead_hit);
    end
  end

  assign bus.gates_off = gates_off_q;
endmodule
`default_nettype wire
